data_c_rr_arbiter: RTL
======================

Name: data_c_rr_arbiter

Overview:
- N-to-1 round-robin arbiter for valid/ready data streams, with one registered output stage.
- Merges NUM requester streams onto one downstream stream.
- The output stage is a two-entry skid buffer, so it sustains 1 beat/clock with no combinational path from m_ready to any s_ready.
- Sits in front of a shared consumer, e.g. a single DMA write port or a shared pipe stage.

Parameters:
- NUM, 4, number of requester streams (2..16).
- DSIZE, 32, data width per stream.
- ISIZE, $clog2(NUM), width of the source-index field (derived; do not override).

Ports:
- clock  input  1  single clock.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  NUM  per-requester valid.
- s_last  input  NUM  per-requester packet-end flag (used only with the optional feature).
- s_data  input  NUM*DSIZE  requester data; stream i occupies bits [i*DSIZE +: DSIZE].
- s_ready  output  NUM  per-requester ready.
- m_valid  output  1  downstream valid, registered.
- m_data  output  DSIZE  downstream data, registered.
- m_sel  output  ISIZE  index of the requester that produced the current m_data beat.
- m_last  output  1  s_last of that beat, registered.
- m_ready  input  1  downstream ready.

Behaviour:
- Reset: m_valid=0, m_data=0, m_sel=0, m_last=0, rr pointer=0, buffer state=EMPTY, lock=0. s_ready=0 while rst_n is low.
- Reset mid-operation: in-flight buffered beats are discarded.
- Handshakes:
  - Slave beat i is accepted when s_valid[i] && s_ready[i].
  - Master beat is accepted when m_valid && m_ready.
  - m_data, m_sel and m_last stay stable while m_valid && !m_ready.
- Arbitration (combinational grant):
  - Search s_valid starting at index ptr, ascending, wrapping from NUM-1 to 0. The first set bit wins.
  - Zero or one s_ready bit is high in any cycle.
  - s_ready[g]=1 only if s_valid[g]=1 and can_take=1, where can_take = (state != FULL), registered.
  - No valid requester: s_ready=0 and ptr is unchanged.
  - ptr is updated only on an accepted slave beat: ptr <= (g+1) mod NUM.
  - Fairness: a continuously requesting stream waits at most NUM-1 grants.
- Buffer state machine, with main register M driving the m_* ports and skid register S:
  - EMPTY:
    - slave accept: load M, go to ONE.
  - ONE:
    - slave accept and no master accept: load S, go to FULL.
    - master accept and no slave accept: go to EMPTY.
    - both: load M, stay ONE.
    - neither: stay ONE.
  - FULL:
    - no slave accept is possible.
    - master accept: S moves to M, go to ONE.
    - otherwise: stay FULL.
- Outputs:
  - m_valid = (state != EMPTY).
  - Latency: input beat to m_valid is 1 clock when the buffer is EMPTY.
  - Throughput: 1 beat/clock while m_ready=1.
- Ordering: beats leave in acceptance order. m_sel always equals the granted index captured with that beat.
- Simultaneous events: for FULL with m_ready=1, can_take is registered low, so the slave side stalls one cycle. This is an accepted bubble after backpressure.

Optional Feature:
- Macro: DATA_C_ARB_LOCK_EN.
- Defined (packet lock):
  - After an accepted beat with s_last[g]=0, lock=1 and the grant is held on g.
  - Other requesters get no s_ready, even if g drops valid.
  - A beat with s_last[g]=1 accepted clears lock. ptr advances only on that beat.
- Undefined:
  - Re-arbitrate every beat. s_last is only forwarded to m_last.
  - No lock register is synthesised.

Decomposition:
- Package data_c_arb_pkg holds:
  - enum BUF_STATE {EMPTY, ONE, FULL};
  - a function rr_pick(valid, ptr) returning the grant index and a found flag.
- One sub-module, data_c_skid_reg: the two-entry M/S buffer with can_take output, DSIZE+ISIZE+1 wide.
- The arbiter top holds the pointer, grant, lock and muxing.

Test Plan:
- Single requester: s_valid=4'b0100, data 0xA0..0xA3, m_ready=1 → m_data=0xA0.. one clock after each accept, m_sel=2, 4 beats in 4 clocks.
- All four requesters valid continuously, m_ready=1, ptr=0 → grant order 0,1,2,3,0,1…, m_sel follows, no bubbles.
- Backpressure: stream 1 active, m_ready=0 for 5 clocks → exactly 2 beats accepted (M, S) and s_ready=0 afterwards. On m_ready=1, the beats come out in order with no loss or duplication.
- Sparse request: ptr=3, s_valid=4'b0011 → grant 0, then ptr=1 → grant 1, then ptr=2.
- Reset asserted while FULL → m_valid=0 and s_ready=0 immediately. After release, the first output is a new beat and ptr=0.
- LOCK_EN: requester 0 sends a 3-beat packet (last on beat 3) while requester 1 is valid → beats 0,0,0 then 1. Requester 0 idles mid-packet for 2 clocks: requester 1 still blocked.

Source files
------------

// File: rtl/data_c_arb_pkg.sv
// Shared types and the round-robin search for the data_c stream arbiter.
package data_c_arb_pkg;

  localparam int MAX_NUM = 16;
  localparam int PTR_W   = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } BUF_STATE;

  typedef struct packed {
    logic             found;
    logic [PTR_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid at or after ptr, wrapping at num (num <= MAX_NUM, ptr < num).
  function automatic rr_pick_t rr_pick(input logic [MAX_NUM-1:0] valid,
                                       input logic [PTR_W-1:0]   ptr,
                                       input int                 num);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int k = 0; k < MAX_NUM; k++) begin
      j = int'(ptr) + k;
      if (j >= num) j = j - num;
      if ((k < num) && !r.found && valid[PTR_W'(j)]) begin
        r.found = 1'b1;
        r.idx   = PTR_W'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/data_c_skid_reg.sv
// Two-entry output buffer: M drives the outputs, S absorbs the beat taken while
// downstream stalls. o_can_take is registered so no ready path runs from i_rd.
module data_c_skid_reg
  import data_c_arb_pkg::*;
#(
  parameter int WIDTH = 35
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_rd,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_can_take
);

  BUF_STATE         r_state;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_s;
  logic             r_valid;
  logic             r_can_take;
  logic             w_rd;

  assign w_rd = r_valid & i_rd;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_m        <= '0;
      r_valid    <= 1'b0;
      r_can_take <= 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (i_wr) begin
            r_m     <= i_din;
            r_valid <= 1'b1;
            r_state <= ONE;
          end
        end
        ONE: begin
          case ({i_wr, w_rd})
            2'b10: begin
              r_state    <= FULL;
              r_can_take <= 1'b0;
            end
            2'b01: begin
              r_state <= EMPTY;
              r_valid <= 1'b0;
            end
            2'b11: r_m <= i_din;
            default: ;
          endcase
        end
        FULL: begin
          if (w_rd) begin
            r_m        <= r_s;
            r_state    <= ONE;
            r_can_take <= 1'b1;
          end
        end
        default: begin
          r_state    <= EMPTY;
          r_valid    <= 1'b0;
          r_can_take <= 1'b1;
        end
      endcase
    end
  end

  // Skid entry is only meaningful while FULL, so it carries no reset.
  always_ff @(posedge clock) begin
    if ((r_state == ONE) && i_wr && !w_rd) r_s <= i_din;
  end

  assign o_valid    = r_valid;
  assign o_dout     = r_m;
  assign o_can_take = r_can_take;

endmodule

// File: rtl/data_c_rr_arbiter.sv
// N-to-1 round-robin stream arbiter with a registered skid output stage.
// Optional packet lock when DATA_C_ARB_LOCK_EN is defined.
module data_c_rr_arbiter
  import data_c_arb_pkg::*;
#(
  parameter int NUM   = 4,
  parameter int DSIZE = 32,
  parameter int ISIZE = $clog2(NUM)
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic [NUM-1:0]       s_valid,
  input  logic [NUM-1:0]       s_last,
  input  logic [NUM*DSIZE-1:0] s_data,
  output logic [NUM-1:0]       s_ready,
  output logic                 m_valid,
  output logic [DSIZE-1:0]     m_data,
  output logic [ISIZE-1:0]     m_sel,
  output logic                 m_last,
  input  logic                 m_ready
);

  localparam int BW = DSIZE + ISIZE + 1;

  logic [ISIZE-1:0] r_ptr;
  rr_pick_t         w_pick;
  logic [ISIZE-1:0] w_gnt;
  logic             w_found;
  logic             w_acc;
  logic             w_can_take;
  logic             w_ptr_adv;
  logic [DSIZE-1:0] w_sdata;
  logic             w_last_in;
  logic [BW-1:0]    w_din;
  logic [BW-1:0]    w_dout;

`ifdef DATA_C_ARB_LOCK_EN
  logic             r_lock;
  logic [ISIZE-1:0] r_lock_idx;
`endif

  always_comb begin
    w_pick  = rr_pick(MAX_NUM'(s_valid), PTR_W'(r_ptr), NUM);
    w_gnt   = '0;
    for (int i = 0; i < NUM; i++) begin
      if (w_pick.idx == PTR_W'(i)) w_gnt = ISIZE'(i);
    end
    w_found = w_pick.found;
`ifdef DATA_C_ARB_LOCK_EN
    // Mid-packet the grant stays on the owner even if it drops valid.
    if (r_lock) begin
      w_gnt   = r_lock_idx;
      w_found = s_valid[r_lock_idx];
    end
`endif
  end

  assign w_acc = w_found & w_can_take & rst_n;

  always_comb begin
    s_ready = '0;
    if (w_acc) s_ready[w_gnt] = 1'b1;
  end

  always_comb begin
    w_sdata   = '0;
    w_last_in = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      if (w_gnt == ISIZE'(i)) begin
        w_sdata   = s_data[i*DSIZE +: DSIZE];
        w_last_in = s_last[i];
      end
    end
  end

`ifdef DATA_C_ARB_LOCK_EN
  assign w_ptr_adv = w_acc & w_last_in;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_acc) begin
      r_lock     <= ~w_last_in;
      r_lock_idx <= w_gnt;
    end
  end
`else
  assign w_ptr_adv = w_acc;
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_ptr_adv) begin
      r_ptr <= (w_gnt == ISIZE'(NUM - 1)) ? '0 : w_gnt + 1'b1;
    end
  end

  assign w_din = {w_last_in, w_gnt, w_sdata};

  data_c_skid_reg #(
    .WIDTH(BW)
  ) u_skid (
    .clock     (clock),
    .rst_n     (rst_n),
    .i_wr      (w_acc),
    .i_din     (w_din),
    .i_rd      (m_ready),
    .o_valid   (m_valid),
    .o_dout    (w_dout),
    .o_can_take(w_can_take)
  );

  assign {m_last, m_sel, m_data} = w_dout;

endmodule
